dummy_bit_scanner: RTL

DUMMY_BIT_SCANNER -- requirements
Module: dummy_bit_scanner

---
 rtl/dummy_bit_scanner.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dummy_bit_scanner.sv
// dummy_bit_scanner: accepts a request bit vector and emits the positions of
// its set bits one per cycle, lowest position first, over a valid/ready port.
// A word with no bits set is retired immediately with a done pulse.
// Optional build macro DUMMY_SCAN_STATS_EN adds a saturating 16-bit counter
// of emitted indices on port stat_cnt_o.

package cf_math_pkg;

    // Number of bits needed to address num_idx items (at least one bit).
    function automatic int unsigned idx_width(input int unsigned num_idx);
        if (num_idx > 32'd1) begin
            return unsigned'($clog2(num_idx));
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

module dummy_bit_scanner #(
    parameter int unsigned WIDTH = 32'd16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [WIDTH-1:0]      req_data_i,
    output logic                  idx_valid_o,
    input  logic                  idx_ready_i,
    output logic [cf_math_pkg::idx_width(WIDTH)-1:0] idx_o,
    output logic                  idx_last_o,
    output logic                  done_o
`ifdef DUMMY_SCAN_STATS_EN
    ,
    output logic [15:0]           stat_cnt_o
`endif
);

    localparam int unsigned IDX_W = cf_math_pkg::idx_width(WIDTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // Trailing-zero count (bit 0 first); an empty vector reports position 0
    // so the index output reads zero while nothing is pending.
    function automatic logic [IDX_W-1:0] tz_count(input logic [WIDTH-1:0] vec);
        logic [IDX_W-1:0] cnt;
        cnt = {IDX_W{1'b0}};
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                cnt = IDX_W'(i);
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

    // True when exactly one bit of the vector is set.
    function automatic logic is_onehot(input logic [WIDTH-1:0] vec);
        logic [WIDTH-1:0] below;
        below = vec - {{(WIDTH-1){1'b0}}, 1'b1};
        return (vec != {WIDTH{1'b0}}) && ((vec & below) == {WIDTH{1'b0}});
    endfunction

    state_e           state_r;
    logic [WIDTH-1:0] pending_r;
    logic             req_ready_r;
    logic             idx_valid_r;
    logic             done_r;

    logic [IDX_W-1:0] tz_s;
    logic             last_s;
    logic [WIDTH-1:0] clear_mask_s;
    logic             idx_hs_s;

    // Index decode straight from the pending register, so it holds under backpressure.
    always_comb begin
        tz_s         = tz_count(pending_r);
        clear_mask_s = {{(WIDTH-1){1'b0}}, 1'b1} << tz_s;
        idx_hs_s     = idx_valid_r & idx_ready_i;
        if (state_r == SCAN) begin
            last_s = is_onehot(pending_r);
        end else begin
            last_s = 1'b0;
        end
    end

    // Main FSM: load words in IDLE, retire one bit per accepted index in SCAN.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            pending_r   <= {WIDTH{1'b0}};
            req_ready_r <= 1'b1;
            idx_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid_i && req_ready_r) begin
                        if (req_data_i != {WIDTH{1'b0}}) begin
                            pending_r   <= req_data_i;
                            state_r     <= SCAN;
                            req_ready_r <= 1'b0;
                            idx_valid_r <= 1'b1;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (idx_hs_s) begin
                        pending_r <= pending_r & ~clear_mask_s;
                        if (last_s) begin
                            state_r     <= IDLE;
                            req_ready_r <= 1'b1;
                            idx_valid_r <= 1'b0;
                            done_r      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    pending_r   <= {WIDTH{1'b0}};
                    req_ready_r <= 1'b1;
                    idx_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef DUMMY_SCAN_STATS_EN
    logic [15:0] stat_cnt_r;

    // Saturating count of index handshakes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_cnt_r <= 16'd0;
        end else if (idx_hs_s && (stat_cnt_r != 16'hFFFF)) begin
            stat_cnt_r <= stat_cnt_r + 16'd1;
        end else begin
            stat_cnt_r <= stat_cnt_r;
        end
    end

    assign stat_cnt_o = stat_cnt_r;
`endif

    assign req_ready_o = req_ready_r;
    assign idx_valid_o = idx_valid_r;
    assign idx_o       = tz_s;
    assign idx_last_o  = last_s;
    assign done_o      = done_r;

endmodule
